// File: rtl/pipelined_segment_adder_pkg.sv
// Shared types and defaults for the pipelined segment adder.
// Default geometry plus the per-segment add helper.
package pipelined_segment_adder_pkg;

    localparam int DEF_W    = 32;
    localparam int DEF_M    = 8;
    localparam int DEF_PIPE = 2;

    localparam int NSEG          = DEF_W / DEF_M;
    localparam int SEG_PER_STAGE = (DEF_PIPE == 0) ? NSEG : NSEG / DEF_PIPE;

    typedef logic [DEF_M-1:0] seg_t;

    typedef struct packed {
        logic [DEF_W-1:0] sum;
        logic [DEF_W-1:0] a_hi;
        logic [DEF_W-1:0] b_hi;
        logic             cy;
        logic             sub;
        logic             vld;
    } stage_t;

    // Returns {carry_out, sum} of one segment.
    function automatic logic [DEF_M:0] add_seg(seg_t a, seg_t b, logic ci);
        return {1'b0, a} + {1'b0, b} + {{DEF_M{1'b0}}, ci};
    endfunction

endpackage

// File: rtl/pipelined_segment_adder_segment_adder.sv
// Combinational M-bit ripple segment.
// Also exposes the carry into its top bit for overflow detection.
module segment_adder #(
    parameter int M = 8
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic         ci,
    output logic [M-1:0] s,
    output logic         co,
    output logic         cm
);

    logic c;

    // Bit-serial ripple; cm captures the carry entering bit M-1.
    always_comb begin
        c  = ci;
        s  = '0;
        cm = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (i == M - 1) begin
                cm = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipelined_segment_adder.sv
// Add/subtract datapath resolved segment by segment across PIPE stages.
// Valid/ready on both sides; backpressure ripples combinationally upstream.
module pipelined_segment_adder
    import pipelined_segment_adder_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int M    = DEF_M,
    parameter int PIPE = DEF_PIPE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         c_out,
    output logic         ovf
);

    localparam int N_SEG   = W / M;
    localparam int N_STG   = (PIPE == 0) ? 1 : PIPE;
    localparam int SEG_STG = N_SEG / N_STG;
    localparam int SPAN    = SEG_STG * M;

    typedef struct packed {
        logic [W-1:0] sum;
        logic [W-1:0] a_hi;
        logic [W-1:0] b_hi;
        logic         cy;
        logic         sub;
        logic         vld;
    } stg_t;

    if (W % M != 0) begin : g_chk_wm
        $error("pipelined_segment_adder: W must be a multiple of M");
    end
    if (PIPE > N_SEG) begin : g_chk_pipe
        $error("pipelined_segment_adder: PIPE exceeds segment count");
    end
    if (PIPE > 0 && (N_SEG % N_STG) != 0) begin : g_chk_div
        $error("pipelined_segment_adder: segment count not divisible by PIPE");
    end

    stg_t           src [N_STG];
    stg_t           res [N_STG];
    stg_t           q   [N_STG];
    logic           ov  [N_STG];
    logic [N_STG:0] ld;
    logic           ovf_q;

    // Sub mode folds into the add: invert B and force the carry-in.
    assign src[0] = '{
        sum:  '0,
        a_hi: a,
        b_hi: sub ? ~b : b,
        cy:   sub | c_in,
        sub:  sub,
        vld:  in_valid
    };

    assign ld[N_STG] = out_ready;

    for (genvar k = 0; k < N_STG; k++) begin : g_stg
        logic [SEG_STG:0]   cc;
        logic [SPAN-1:0]    ps;
        logic [SEG_STG-1:0] cm;
        logic [W-1:0]       sm;

        assign cc[0] = src[k].cy;

        for (genvar j = 0; j < SEG_STG; j++) begin : g_seg
            localparam int LO = (k * SEG_STG + j) * M;
            segment_adder #(.M(M)) u_seg (
                .a  (src[k].a_hi[LO +: M]),
                .b  (src[k].b_hi[LO +: M]),
                .ci (cc[j]),
                .s  (ps[j*M +: M]),
                .co (cc[j+1]),
                .cm (cm[j])
            );
        end

        // Splice this stage's resolved segments into the running sum.
        always_comb begin
            sm = src[k].sum;
            sm[k*SPAN +: SPAN] = ps;
        end

        assign res[k] = '{
            sum:  sm,
            a_hi: src[k].a_hi,
            b_hi: src[k].b_hi,
            cy:   cc[SEG_STG],
            sub:  src[k].sub,
            vld:  src[k].vld
        };

        assign ov[k] = cm[SEG_STG-1] ^ cc[SEG_STG];

        if (k > 0) begin : g_link
            assign src[k] = q[k-1];
        end

        if (PIPE > 0) begin : g_reg
            assign ld[k] = !q[k].vld || ld[k+1];

            // Stage register: loads when empty or when its beat moves on.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q[k] <= '0;
                end else if (ld[k]) begin
                    q[k] <= res[k];
                end
            end

            if (k == N_STG - 1) begin : g_ovf
                // Overflow is only known once the MSB segment resolves.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ovf_q <= 1'b0;
                    end else if (ld[k]) begin
                        ovf_q <= ov[k];
                    end
                end
            end
        end
    end

    if (PIPE == 0) begin : g_comb
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign s         = res[0].sum;
        assign c_out     = res[0].cy;
        assign ovf       = ov[0];
    end else begin : g_piped
        assign in_ready  = ld[0];
        assign out_valid = q[N_STG-1].vld;
        assign s         = q[N_STG-1].sum;
        assign c_out     = q[N_STG-1].cy;
        assign ovf       = ovf_q;
    end

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Self-checking bench: directed vectors, streaming, backpressure,
// reset flush and a randomized phase against a queue-based model.
module tb_pipelined_segment_adder;

    parameter int PIPE = 2;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c_in;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          c_out;
    logic          ovf;

    always #5 clk = ~clk;

    pipelined_segment_adder #(.W(32), .M(8), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int nout   = 0;
    bit lat_chk = 0;
    bit prev_stall = 0;
    logic [33:0] hold_v;
    logic [33:0] last_v;
    logic [33:0] exp_q [$];
    int          acc_q [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // {ovf, carry, sum} straight from two's-complement arithmetic.
    function automatic logic [33:0] model(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic ci,
                                          input logic sb);
        logic [31:0] be;
        logic [32:0] t;
        logic        ov;
        be = sb ? ~y : y;
        t  = {1'b0, x} + {1'b0, be} + 33'(sb ? 1'b1 : ci);
        ov = (x[31] == be[31]) && (t[31] != x[31]);
        return {ov, t[32], t[31:0]};
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Compare process: every output transfer is checked against the model.
    always @(negedge clk) begin
        logic [33:0] e;
        int          t0;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_stall = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c_in, sub));
                acc_q.push_back(cyc);
            end
            if (prev_stall && PIPE > 0) begin
                chk("stall_hold", {ovf, c_out, s}, hold_v);
                chk("stall_valid", out_valid, 1);
            end
            if (out_valid && (out_ready || PIPE > 0))
                chk("valid_has_beat", exp_q.size() != 0, 1);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                t0 = acc_q.pop_front();
                chk("s", s, e[31:0]);
                chk("c_out", c_out, e[32]);
                chk("ovf", ovf, e[33]);
                if (lat_chk) chk("latency", cyc - t0, PIPE);
                last_v = {ovf, c_out, s};
                nout++;
            end
            prev_stall = out_valid && !out_ready;
            hold_v = {ovf, c_out, s};
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic sb);
        int n;
        bit got;
        in_valid = 1;
        a = x;
        b = y;
        c_in = ci;
        sub = sb;
        n = 0;
        got = 0;
        do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 50);
        chk("send_accepted", got, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic directed(input string nm, input logic [31:0] x,
                            input logic [31:0] y, input logic ci,
                            input logic sb, input logic [33:0] want);
        send(x, y, ci, sb);
        drain();
        chk(nm, last_v, want);
    endtask

    initial begin
        logic [31:0] bp_a [3];
        logic [31:0] bp_b [3];
        int n0;
        int accepted;
        int idx;
        bit got;

        rst = 1;
        in_valid = 0;
        a = '0;
        b = '0;
        c_in = 0;
        sub = 0;
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_s", s, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_ovf", ovf, 0);
        rst = 0;
        @(posedge clk);
        #1;

        lat_chk = 1;
        directed("add_wrap", 32'hFFFF_FFFF, 32'h1, 0, 0,
                 {1'b0, 1'b1, 32'h0});
        directed("sub_borrow", 32'h5, 32'h7, 0, 1,
                 {1'b0, 1'b0, 32'hFFFF_FFFE});
        directed("sub_ovf", 32'h8000_0000, 32'h1, 0, 1,
                 {1'b1, 1'b1, 32'h7FFF_FFFF});
        directed("add_cin_ovf", 32'h7FFF_FFFF, 32'h0, 1, 0,
                 {1'b1, 1'b0, 32'h8000_0000});
        directed("sub_ign_cin", 32'h10, 32'h3, 1, 1,
                 {1'b0, 1'b1, 32'hD});

        n0 = nout;
        for (int i = 0; i < 16; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        drain();
        chk("stream_count", nout - n0, 16);
        lat_chk = 0;

        for (int i = 0; i < 3; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        n0 = nout;
        out_ready = 0;
        accepted = 0;
        idx = 0;
        in_valid = 1;
        a = bp_a[0];
        b = bp_b[0];
        c_in = 0;
        sub = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (got) begin
                accepted++;
                idx++;
                if (idx < 3) begin
                    a = bp_a[idx];
                    b = bp_b[idx];
                end else begin
                    in_valid = 0;
                end
            end
        end
        chk("bp_accepted", accepted, (PIPE < 3) ? PIPE : 3);
        chk("bp_in_ready", in_ready, PIPE >= 3);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1;
        while (idx < 3) begin
            send(bp_a[idx], bp_b[idx], 0, 0);
            idx++;
        end
        drain();
        chk("bp_count", nout - n0, 3);

        out_ready = (PIPE == 0);
        send(32'h1234_5678, 32'h1111_1111, 0, 0);
        send(32'hDEAD_BEEF, 32'h0000_0001, 0, 1);
        rst = 1;
        #1;
        chk("rst_flush_valid", out_valid, 0);
        n0 = nout;
        @(posedge clk);
        #1;
        rst = 0;
        out_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_stale", nout - n0, 0);
        lat_chk = 1;
        directed("post_rst", 32'h0000_00FF, 32'h0000_0001, 0, 0,
                 {1'b0, 1'b0, 32'h0000_0100});
        chk("post_rst_count", nout - n0, 1);
        lat_chk = 0;

        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'h7FFF_FFFF;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            c_in = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        out_ready = 1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
